// File: rtl/alu.sv
// Registered 64-bit ALU: eight operations with optional operand inversion,
// a visible ripple-carry chain and V/C/N/Z status, all captured on one edge.
module alu #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic [4:0]       FS,
    input  logic             Cin,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       stat,
    output logic [WIDTH:0]   Cout
);

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_ADD   = 3'b010,
        OP_XOR   = 3'b011,
        OP_SHR   = 3'b100,
        OP_SHL   = 3'b101,
        OP_ZERO  = 3'b110,
        OP_ONES  = 3'b111
    } op_e;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH:0]   cout_d;
    logic [3:0]       stat_d;
    op_e              op;

    logic [WIDTH-1:0] f_q;
    logic [3:0]       stat_q;
    logic [WIDTH:0]   cout_q;

    assign op = op_e'(FS[4:2]);
    assign a  = FS[1] ? ~inA : inA;
    assign b  = FS[0] ? ~inB : inB;

    // Explicit ripple chain so every carry is observable on Cout, whatever the operation.
    always_comb begin
        cout_d    = '0;
        sum       = '0;
        cout_d[0] = Cin | FS[0];
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]      = a[i] ^ b[i] ^ cout_d[i];
            cout_d[i+1] = (a[i] & b[i]) | (cout_d[i] & (a[i] ^ b[i]));
        end
    end

    always_comb begin
        result_d = '0;
        unique case (op)
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_ADD:  result_d = sum;
            OP_XOR:  result_d = a ^ b;
            OP_SHR:  result_d = {1'b0, a[WIDTH-1:1]};
            OP_SHL:  result_d = {a[WIDTH-2:0], 1'b0};
            OP_ZERO: result_d = '0;
            OP_ONES: result_d = '1;
            default: result_d = '0;
        endcase
    end

    // Carry and overflow only carry meaning for the adder; elsewhere they read as 0.
    always_comb begin
        stat_d    = '0;
        stat_d[0] = (result_d == '0);
        stat_d[1] = result_d[WIDTH-1];
        if (op == OP_ADD) begin
            stat_d[2] = cout_d[WIDTH];
            stat_d[3] = cout_d[WIDTH] ^ cout_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q    <= '0;
            stat_q <= '0;
            cout_q <= '0;
        end else begin
            f_q    <= result_d;
            stat_q <= stat_d;
            cout_q <= cout_d;
        end
    end

    assign F    = f_q;
    assign stat = stat_q;
    assign Cout = cout_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus queues hand-computed expectations,
// a negedge monitor pops one per issued operation and compares.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [63:0] inA;
    logic [63:0] inB;
    logic [4:0]  FS;
    logic        Cin;
    logic [63:0] F;
    logic [3:0]  stat;
    logic [64:0] Cout;

    typedef struct {
        string       name;
        logic [63:0] f;
        logic [3:0]  st;
        logic [64:0] cout;
        logic [64:0] coutMask;
    } exp_t;

    exp_t expQ[$];
    logic issued    = 1'b0;
    logic validPipe = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;

    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [64:0] NOMASK = 65'h0;
    localparam logic [64:0] EDGES  = {1'b1, 63'h0, 1'b1};
    localparam logic [64:0] TOP2   = {2'b11, 63'h0};
    localparam logic [64:0] ALLM   = {65{1'b1}};

    alu #(.WIDTH(64)) dut (
        .clk  (clk),
        .rst  (rst),
        .inA  (inA),
        .inB  (inB),
        .FS   (FS),
        .Cin  (Cin),
        .F    (F),
        .stat (stat),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [64:0] act, input logic [64:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] fs, input logic ci,
                                 input logic [63:0] expF, input logic [3:0] expStat,
                                 input logic [64:0] expCout, input logic [64:0] mask);
        exp_t e;
        @(posedge clk);
        #2;
        inA    = a;
        inB    = b;
        FS     = fs;
        Cin    = ci;
        issued = 1'b1;
        e.name = name;
        e.f = expF;
        e.st = expStat;
        e.cout = expCout;
        e.coutMask = mask;
        expQ.push_back(e);
    endtask

    always @(posedge clk) validPipe <= issued;

    always @(negedge clk) begin
        if (validPipe && !rst) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL scoreboard: output with no expectation queued");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput({e.name, ".F"}, {1'b0, F}, {1'b0, e.f});
                checkOutput({e.name, ".stat"}, {61'h0, stat}, {61'h0, e.st});
                if (e.coutMask != NOMASK)
                    checkOutput({e.name, ".Cout"}, Cout & e.coutMask, e.cout & e.coutMask);
            end
        end
    end

    initial begin
        rst = 1'b1;
        inA = '0;
        inB = '0;
        FS  = '0;
        Cin = 1'b0;
        #3;
        checkOutput("reset.F", {1'b0, F}, 65'h0);
        checkOutput("reset.stat", {61'h0, stat}, 65'h0);
        checkOutput("reset.Cout", Cout, 65'h0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus("and",     64'd13, 64'd6, 5'b00000, 1'b0, 64'd4,  4'b0000, 65'h18, ALLM);
        applyStimulus("or",      64'd13, 64'd6, 5'b00100, 1'b0, 64'd15, 4'b0000, 65'h0, NOMASK);
        applyStimulus("xor",     64'd13, 64'd6, 5'b01100, 1'b0, 64'd11, 4'b0000, 65'h0, NOMASK);
        applyStimulus("add",     64'd13, 64'd6, 5'b01000, 1'b0, 64'd19, 4'b0000, 65'h18, ALLM);
        applyStimulus("sub",     64'd13, 64'd6, 5'b01001, 1'b0, 64'd7,  4'b0100, EDGES, EDGES);
        applyStimulus("subBorrow", 64'd6, 64'd13, 5'b01001, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 4'b0010, {1'b0, 63'h0, 1'b1}, EDGES);
        applyStimulus("andNotB", 64'd13, 64'd6, 5'b00001, 1'b0, 64'd9,  4'b0000, 65'h0, NOMASK);
        applyStimulus("shr",     64'd13, 64'd6, 5'b10000, 1'b0, 64'd6,  4'b0000, 65'h0, NOMASK);
        applyStimulus("shl",     64'd13, 64'd6, 5'b10100, 1'b0, 64'd26, 4'b0000, 65'h0, NOMASK);
        applyStimulus("shlDrop", 64'h8000_0000_0000_0001, 64'd0, 5'b10100, 1'b0, 64'd2, 4'b0000, 65'h0, NOMASK);
        applyStimulus("shrDrop", 64'h8000_0000_0000_0001, 64'd0, 5'b10000, 1'b0, 64'h4000_0000_0000_0000, 4'b0000, 65'h0, NOMASK);
        applyStimulus("zero",    64'd13, 64'd6, 5'b11000, 1'b0, 64'd0,  4'b0001, 65'h0, NOMASK);
        applyStimulus("notA",    64'd13, 64'd0, 5'b01010, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2, 4'b0010, 65'h0, ALLM);
        applyStimulus("carryIn", 64'd13, 64'd1, 5'b01000, 1'b1, 64'd15, 4'b0000, 65'h3, ALLM);
        applyStimulus("wrap",    ONES,   64'd1, 5'b01000, 1'b0, 64'd0,  4'b0101, TOP2, TOP2);
        applyStimulus("ovf",     64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0, 64'h8000_0000_0000_0000, 4'b1010, {2'b01, 63'h0}, TOP2);
        applyStimulus("ones",    64'd13, 64'd6, 5'b11100, 1'b0, ONES,   4'b0010, 65'h0, NOMASK);

        @(posedge clk);
        #2;
        issued = 1'b0;

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
        if (expQ.size() != 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end

        // Outputs still hold the all-ones result; reset between edges must clear them at once.
        @(posedge clk);
        #3;
        checkOutput("preReset.F", {1'b0, F}, {1'b0, ONES});
        rst = 1'b1;
        #1;
        checkOutput("midReset.F", {1'b0, F}, 65'h0);
        checkOutput("midReset.stat", {61'h0, stat}, 65'h0);
        checkOutput("midReset.Cout", Cout, 65'h0);
        @(posedge clk);
        #1;
        checkOutput("heldReset.F", {1'b0, F}, 65'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 64-bit registered arithmetic/logic unit for the datapath.
- A 5-bit function select FS chooses one of eight operations. FS[1] and FS[0] optionally invert the A and B operands.
- Produces the result F, a 4-bit status word and the full 65-bit ripple-carry vector.
- All outputs are registered on one clock edge, with asynchronous active-high reset.

Parameters:
- WIDTH, 64, datapath width. Cout is WIDTH+1 bits. All values in this document assume 64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- inA  input  64  operand A
- inB  input  64  operand B
- FS  input  5  function select: FS[4:2] is the operation, FS[1] inverts A, FS[0] inverts B
- Cin  input  1  external carry-in
- F  output  64  registered result
- stat  output  4  registered status: stat[3]=V overflow, stat[2]=C carry, stat[1]=N negative, stat[0]=Z zero
- Cout  output  65  registered carry chain: Cout[0] is the effective carry-in, Cout[i+1] is the carry out of bit i, Cout[64] is the final carry

Behaviour:
- Reset: while rst=1, F, stat and Cout are asynchronously forced to 0. The first update after rst deasserts happens at the next rising clk edge.
- Latency: one cycle.
  - Combinational result computed from inA/inB/FS/Cin.
  - Captured into F, stat and Cout on each rising clk edge.
  - No enable and no handshake; a new operation can be issued every cycle.
- Operand conditioning:
  - a = FS[1] ? ~inA : inA
  - b = FS[0] ? ~inB : inB
  - Conditioning applies to every operation.
- Effective carry-in: ci = Cin | FS[0]. Subtraction (FS=01001) therefore works with Cin=0.
- Adder:
  - 64-bit ripple-carry a + b + ci.
  - Cout holds the carry vector for every FS value, not only the add operation.
- Operation by FS[4:2]:
  - 000: a & b
  - 001: a | b
  - 010: a + b + ci, with the result wrapping modulo 2^64
  - 011: a ^ b
  - 100: a >> 1, logical, MSB filled with 0
  - 101: a << 1, LSB filled with 0
  - 110: all zeros
  - 111: all ones
- Status:
  - Z = (result == 0)
  - N = result[63]
  - For FS[4:2]=010:
    - C = Cout[64]
    - V = Cout[64] ^ Cout[63], i.e. signed overflow
  - For all other operations, C=0 and V=0.
- Boundaries:
  - 0xFFFF_FFFF_FFFF_FFFF + 1 gives F=0, C=1, Z=1, V=0.
  - 0x7FFF_FFFF_FFFF_FFFF + 1 gives V=1, N=1.
  - Subtraction A-B: C=1 means no borrow.
  - Bits shifted out by a shift are discarded.
  - Asserting rst mid-stream clears the outputs immediately, with no pending state.

Test Plan:
- Reset, then logic ops with inA=13, inB=6, Cin=0; each result appears one clk edge after FS is applied:
  - FS=00000 -> F=4
  - FS=00100 -> F=15
  - FS=01100 -> F=11
  - Each with stat=0000.
- Arithmetic with the same operands:
  - FS=01000 -> F=19, C=0, V=0
  - FS=01001 (A-B) -> F=7, stat C=1, Cout[0]=1
- Shifts and constants with inA=13:
  - FS=10000 -> F=6
  - FS=10100 -> F=26
  - FS=11000 -> F=0, Z=1
  - FS=11100 -> F=0xFFFF_FFFF_FFFF_FFFF, N=1
- Invert A with FS=01010, inB=0, Cin=0 -> F=0xFFFF_FFFF_FFFF_FFF2, N=1, C=0.
- Carry-in with FS=01000, inA=13, inB=1, Cin=1 -> F=15.
- Boundaries with FS=01000:
  - inA=all ones, inB=1 -> F=0, Z=1, C=1, Cout[64]=1.
  - inA=0x7FFF_FFFF_FFFF_FFFF, inB=1 -> V=1, N=1.
  - Assert rst asynchronously between edges -> F, stat and Cout go to 0 immediately.
